// File: rtl/sha256_bench_sched_pkg.sv
// Shared types and constants for the SHA256 benchmark scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_bench_pkg;

   localparam int DEF_CNT_W  = 30;
   localparam int DEF_ITER_W = 16;

   localparam logic CORE_HLS  = 1'b0;
   localparam logic CORE_VHDL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_RECORD,
      ST_DONE
   } state_t;

   // One-hot start vector for the selected core.
   function automatic logic [1:0] core_onehot(input logic sel);
      return (sel == CORE_VHDL) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sha256_bench_sched_if.sv
// Command, core-handshake and result bundle of the benchmark scheduler.
// Latency: n/a (wires only).
// Backpressure: none; all transfers are single-cycle pulses or held levels.
// master = test-control side (drives cmd_*, dut_done); slave = the scheduler.
interface sha256_bench_sched_if
   import sha256_bench_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int ITER_W = DEF_ITER_W
);
   logic                     cmd_start;
   logic                     cmd_sel;
   logic [ITER_W-1:0]        cmd_iters;
   logic                     cmd_err;
   logic                     busy;
   logic [1:0]               dut_start;
   logic [1:0]               dut_done;
   logic                     res_valid;
   logic                     res_timeout;
   logic                     res_core;
   logic [ITER_W-1:0]        res_runs;
   logic [CNT_W-1:0]         res_last;
   logic [CNT_W-1:0]         res_min;
   logic [CNT_W-1:0]         res_max;
   logic [CNT_W+ITER_W-1:0]  res_total;

   modport master (
      output cmd_start, cmd_sel, cmd_iters, dut_done,
      input  cmd_err, busy, dut_start, res_valid, res_timeout, res_core,
             res_runs, res_last, res_min, res_max, res_total
   );

   modport slave (
      input  cmd_start, cmd_sel, cmd_iters, dut_done,
      output cmd_err, busy, dut_start, res_valid, res_timeout, res_core,
             res_runs, res_last, res_min, res_max, res_total
   );
endinterface

// File: rtl/sha256_bench_sched_counter.sv
// Saturating per-run cycle counter.
// Latency: count updates one cycle after clr/en.
// Backpressure: none; holds at all-ones once saturated.
// Ports: clk, rst (sync, active-high), clr (priority over en), en, count, sat.
module bench_cycle_counter
   import sha256_bench_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             sat
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (en && (r_count != CNT_MAX)) begin
         r_count <= r_count + CNT_ONE;
      end
   end

   assign count = r_count;
   assign sat   = (r_count == CNT_MAX);
endmodule

// File: rtl/sha256_bench_sched.sv
// Launches one of two SHA256 cores N times and collects last/min/max/total run cycles.
// Latency: start pulse 1 cycle after accept; 2 cycles of overhead per run; result 2 cycles after last done.
// Backpressure: none; cmd_start while busy is dropped, no queuing.
// Ports: clk, rst (sync, active-high); bus (slave) carries cmd_*, busy, dut_start/dut_done, res_*.
module sha256_bench_sched
   import sha256_bench_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int ITER_W = DEF_ITER_W
) (
   input  logic                 clk,
   input  logic                 rst,
   sha256_bench_sched_if.slave  bus
);
   localparam int TOT_W = CNT_W + ITER_W;

   state_t               r_state;
   logic                 r_sel;
   logic [ITER_W-1:0]    r_iters;
   logic                 r_cmd_err;
   logic                 r_busy;
   logic [1:0]           r_dut_start;
   logic                 r_res_valid;
   logic                 r_res_timeout;
   logic [ITER_W-1:0]    r_res_runs;
   logic [CNT_W-1:0]     r_res_last;
   logic [CNT_W-1:0]     r_res_min;
   logic [CNT_W-1:0]     r_res_max;
   logic [TOT_W-1:0]     r_res_total;

   logic                 w_done;
   logic                 w_cnt_clr;
   logic                 w_cnt_en;
   logic [CNT_W-1:0]     w_count;
   logic                 w_sat;
   logic [ITER_W-1:0]    w_runs_nxt;

   assign w_done     = bus.dut_done[r_sel];
   assign w_runs_nxt = r_res_runs + ITER_W'(1);

   // The counter is zero on entry to LAUNCH and counts LAUNCH plus every
   // WAIT cycle except the one where done is seen, so during WAIT cycle k it
   // reads k, and in RECORD it holds exactly the run length.
   assign w_cnt_clr = (r_state != ST_LAUNCH) && (r_state != ST_WAIT);
   assign w_cnt_en  = (r_state == ST_LAUNCH) || ((r_state == ST_WAIT) && !w_done);

   bench_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_cnt_clr),
      .en    (w_cnt_en),
      .count (w_count),
      .sat   (w_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_sel         <= CORE_HLS;
         r_iters       <= '0;
         r_cmd_err     <= 1'b0;
         r_busy        <= 1'b0;
         r_dut_start   <= 2'b00;
         r_res_valid   <= 1'b0;
         r_res_timeout <= 1'b0;
         r_res_runs    <= '0;
         r_res_last    <= '0;
         r_res_min     <= '1;
         r_res_max     <= '0;
         r_res_total   <= '0;
      end else begin
         r_cmd_err   <= 1'b0;
         r_dut_start <= 2'b00;
         r_res_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.cmd_start) begin
                  if (bus.cmd_iters == '0) begin
                     r_cmd_err <= 1'b1;
                  end else begin
                     r_sel         <= bus.cmd_sel;
                     r_iters       <= bus.cmd_iters;
                     r_res_timeout <= 1'b0;
                     r_res_runs    <= '0;
                     r_res_last    <= '0;
                     r_res_min     <= '1;
                     r_res_max     <= '0;
                     r_res_total   <= '0;
                     r_busy        <= 1'b1;
                     r_dut_start   <= core_onehot(bus.cmd_sel);
                     r_state       <= ST_LAUNCH;
                  end
               end
            end
            ST_LAUNCH: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done arriving in the saturated cycle still counts as a run.
               if (w_done) begin
                  r_state <= ST_RECORD;
               end else if (w_sat) begin
                  r_res_timeout <= 1'b1;
                  r_res_valid   <= 1'b1;
                  r_state       <= ST_DONE;
               end
            end
            ST_RECORD: begin
               r_res_last  <= w_count;
               r_res_total <= r_res_total + TOT_W'(w_count);
               r_res_runs  <= w_runs_nxt;
               if (w_count < r_res_min) r_res_min <= w_count;
               if (w_count > r_res_max) r_res_max <= w_count;
               if (w_runs_nxt == r_iters) begin
                  r_res_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_dut_start <= core_onehot(r_sel);
                  r_state     <= ST_LAUNCH;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_err     = r_cmd_err;
   assign bus.busy        = r_busy;
   assign bus.dut_start   = r_dut_start;
   assign bus.res_valid   = r_res_valid;
   assign bus.res_timeout = r_res_timeout;
   assign bus.res_core    = r_sel;
   assign bus.res_runs    = r_res_runs;
   assign bus.res_last    = r_res_last;
   assign bus.res_min     = r_res_min;
   assign bus.res_max     = r_res_max;
   assign bus.res_total   = r_res_total;
endmodule

// File: tb/tb_sha256_bench_sched.sv
// Testbench for sha256_bench_sched: timed directed stimulus with a queue-based scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sha256_bench_sched;
   import sha256_bench_pkg::*;

   localparam int CNT_W  = 4;
   localparam int ITER_W = 16;

   typedef struct {
      logic [1:0] val;
      int         cyc;
   } start_exp_t;

   typedef struct {
      int   cyc;
      logic timeout;
      logic core;
      int   runs;
      int   last;
      int   min;
      int   max;
      int   total;
   } res_exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;

   start_exp_t start_q[$];
   res_exp_t   res_q[$];
   int         err_q[$];

   sha256_bench_sched_if #(.CNT_W(CNT_W), .ITER_W(ITER_W)) bus ();

   sha256_bench_sched #(.CNT_W(CNT_W), .ITER_W(ITER_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   start_exp_t m_se;
   res_exp_t   m_re;
   int         m_ec;

   always @(negedge clk) begin
      if (bus.dut_start != 2'b00) begin
         if (start_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_start: got dut_start=%b at cycle %0d, required none", bus.dut_start, cyc);
         end else begin
            m_se = start_q.pop_front();
            check("dut_start_val", 64'(bus.dut_start), 64'(m_se.val));
            check("dut_start_cyc", 64'(cyc), 64'(m_se.cyc));
         end
      end
      if (bus.res_valid) begin
         if (res_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_res_valid: got res_valid=1 at cycle %0d, required none", cyc);
         end else begin
            m_re = res_q.pop_front();
            check("res_cyc",     64'(cyc),             64'(m_re.cyc));
            check("res_timeout", 64'(bus.res_timeout), 64'(m_re.timeout));
            check("res_core",    64'(bus.res_core),    64'(m_re.core));
            check("res_runs",    64'(bus.res_runs),    64'(m_re.runs));
            check("res_last",    64'(bus.res_last),    64'(m_re.last));
            check("res_min",     64'(bus.res_min),     64'(m_re.min));
            check("res_max",     64'(bus.res_max),     64'(m_re.max));
            check("res_total",   64'(bus.res_total),   64'(m_re.total));
         end
      end
      if (bus.cmd_err) begin
         if (err_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_cmd_err: got cmd_err=1 at cycle %0d, required none", cyc);
         end else begin
            m_ec = err_q.pop_front();
            check("cmd_err_cyc", 64'(cyc), 64'(m_ec));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   // Issues one batch and plays the core: done comes lat[i] cycles after each
   // LAUNCH cycle. Expected start/result cycles are derived from the timing
   // contract: LAUNCH = accept+1, next LAUNCH = done+2, res_valid = last done+2.
   task automatic run_batch(input logic sel, input int iters, input int lat[4],
                            input int e_last, input int e_min, input int e_max, input int e_tot);
      int s;
      int d;
      res_exp_t r;
      s = cyc + 1;
      d = s;
      for (int i = 0; i < iters; i++) begin
         start_q.push_back('{val: (sel ? 2'b10 : 2'b01), cyc: s});
         d = s + lat[i];
         s = d + 2;
      end
      r = '{cyc: d + 2, timeout: 1'b0, core: sel, runs: iters,
            last: e_last, min: e_min, max: e_max, total: e_tot};
      res_q.push_back(r);

      bus.cmd_sel   = sel;
      bus.cmd_iters = ITER_W'(iters);
      bus.cmd_start = 1'b1;
      step();
      bus.cmd_start = 1'b0;
      check("busy_in_launch", 64'(bus.busy), 64'd1);
      s = cyc;
      for (int i = 0; i < iters; i++) begin
         wait_until(s + lat[i]);
         bus.dut_done[sel] = 1'b1;
         step();
         bus.dut_done = 2'b00;
         s = s + lat[i] + 2;
      end
      wait_until(d + 2);
      check("busy_in_done", 64'(bus.busy), 64'd1);
      step();
      check("busy_after_done", 64'(bus.busy), 64'd0);
      step();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int s;
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.cmd_start = 1'b0;
      bus.cmd_sel   = 1'b0;
      bus.cmd_iters = '0;
      bus.dut_done  = 2'b00;
      step();
      step();
      step();
      rst = 1'b0;

      // Reset values
      check("rst_busy",      64'(bus.busy),      64'd0);
      check("rst_dut_start", 64'(bus.dut_start), 64'd0);
      check("rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("rst_cmd_err",   64'(bus.cmd_err),   64'd0);
      check("rst_res_min",   64'(bus.res_min),   64'hF);
      check("rst_res_total", 64'(bus.res_total), 64'd0);
      check("rst_res_runs",  64'(bus.res_runs),  64'd0);
      step();

      // Single run on the HLS core, done 5 cycles after LAUNCH
      run_batch(CORE_HLS, 1, '{5, 0, 0, 0}, 5, 5, 5, 5);

      // Batch of three on the VHDL core: 3, 7, 2
      run_batch(CORE_VHDL, 3, '{3, 7, 2, 0}, 2, 2, 7, 12);

      // Zero iterations: error pulse only
      err_q.push_back(cyc + 1);
      bus.cmd_sel   = CORE_VHDL;
      bus.cmd_iters = '0;
      bus.cmd_start = 1'b1;
      step();
      bus.cmd_start = 1'b0;
      check("zero_iters_busy0", 64'(bus.busy), 64'd0);
      step();
      check("zero_iters_busy1", 64'(bus.busy), 64'd0);
      step();

      // Timeout: done never comes, counter saturates after 15 WAIT cycles
      s = cyc + 1;
      start_q.push_back('{val: 2'b10, cyc: s});
      res_q.push_back('{cyc: s + 16, timeout: 1'b1, core: 1'b1, runs: 0,
                        last: 0, min: 15, max: 0, total: 0});
      bus.cmd_sel   = CORE_VHDL;
      bus.cmd_iters = ITER_W'(2);
      bus.cmd_start = 1'b1;
      step();
      bus.cmd_start = 1'b0;
      wait_until(s + 17);
      check("timeout_busy_after", 64'(bus.busy), 64'd0);
      step();

      // Interference: other core's done and a new cmd_start during WAIT
      s = cyc + 1;
      start_q.push_back('{val: 2'b01, cyc: s});
      res_q.push_back('{cyc: s + 8, timeout: 1'b0, core: 1'b0, runs: 1,
                        last: 6, min: 6, max: 6, total: 6});
      bus.cmd_sel   = CORE_HLS;
      bus.cmd_iters = ITER_W'(1);
      bus.cmd_start = 1'b1;
      step();
      bus.cmd_start = 1'b0;
      wait_until(s + 2);
      bus.dut_done  = 2'b10;
      bus.cmd_sel   = CORE_VHDL;
      bus.cmd_iters = ITER_W'(5);
      bus.cmd_start = 1'b1;
      step();
      bus.cmd_start = 1'b0;
      bus.dut_done  = 2'b00;
      check("interf_busy", 64'(bus.busy), 64'd1);
      wait_until(s + 6);
      bus.dut_done = 2'b01;
      step();
      bus.dut_done = 2'b00;
      wait_until(s + 9);
      check("interf_busy_after", 64'(bus.busy), 64'd0);
      step();

      // Reset in the middle of WAIT
      s = cyc + 1;
      start_q.push_back('{val: 2'b01, cyc: s});
      bus.cmd_sel   = CORE_HLS;
      bus.cmd_iters = ITER_W'(2);
      bus.cmd_start = 1'b1;
      step();
      bus.cmd_start = 1'b0;
      wait_until(s + 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_busy",      64'(bus.busy),      64'd0);
      check("midrst_dut_start", 64'(bus.dut_start), 64'd0);
      check("midrst_res_min",   64'(bus.res_min),   64'hF);
      check("midrst_res_runs",  64'(bus.res_runs),  64'd0);
      check("midrst_res_total", 64'(bus.res_total), 64'd0);
      step();
      step();

      // Normal batch after reset
      run_batch(CORE_VHDL, 2, '{4, 3, 0, 0}, 3, 3, 4, 7);

      step();
      step();
      check("start_q_drained", 64'(start_q.size()), 64'd0);
      check("res_q_drained",   64'(res_q.size()),   64'd0);
      check("err_q_drained",   64'(err_q.size()),   64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
